// File: rtl/injection_sequencer.sv
// Runs one address_generator through a bounded burst of memory-injection requests:
// it initializes the generator once, then issues one request per generator address.
//
// state | meaning
// IDLE  | waiting for start; config inputs are sampled when start arrives
// INIT  | one-cycle generator initialize pulse
// ISSUE | request_valid held until the handshake; the generator advances on the handshake
// GAP   | programmable idle cycles between consecutive requests
// DONE  | one-cycle done pulse, then back to IDLE

module injection_sequencer #(
   parameter int ADDRESS_WIDTH = 48,
   parameter int COUNT_WIDTH   = 32
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic                     start,
   input  logic                     abort,
   input  logic [COUNT_WIDTH-1:0]   transaction_count,
   input  logic [COUNT_WIDTH-1:0]   gap_cycles,
   output logic                     generator_initialize,
   output logic                     generator_enable,
   input  logic [ADDRESS_WIDTH-1:0] generator_address,
   output logic                     request_valid,
   input  logic                     request_ready,
   output logic [ADDRESS_WIDTH-1:0] request_address,
   output logic                     busy,
   output logic                     done,
   output logic [COUNT_WIDTH-1:0]   issued_count
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      ISSUE = 3'd2,
      GAP   = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = '0;
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                   state_q, state_d;
   logic [COUNT_WIDTH-1:0]   count_lat_q, count_lat_d;
   logic [COUNT_WIDTH-1:0]   gap_lat_q, gap_lat_d;
   logic [COUNT_WIDTH-1:0]   issued_q, issued_d;
   logic [COUNT_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
   logic                     abort_pend_q, abort_pend_d;
   logic                     abort_eff;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         count_lat_q  <= '0;
         gap_lat_q    <= '0;
         issued_q     <= '0;
         gap_cnt_q    <= '0;
         abort_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_lat_q  <= count_lat_d;
         gap_lat_q    <= gap_lat_d;
         issued_q     <= issued_d;
         gap_cnt_q    <= gap_cnt_d;
         abort_pend_q <= abort_pend_d;
      end
   end

   // An abort arriving this cycle is treated as already pending, so it acts at this exit point.
   assign abort_eff = abort_pend_q | abort;

   always_comb begin
      state_d              = state_q;
      count_lat_d          = count_lat_q;
      gap_lat_d            = gap_lat_q;
      issued_d             = issued_q;
      gap_cnt_d            = gap_cnt_q;
      abort_pend_d         = abort_pend_q;
      generator_initialize = 1'b0;
      generator_enable     = 1'b0;
      request_valid        = 1'b0;
      done                 = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               count_lat_d  = transaction_count;
               gap_lat_d    = gap_cycles;
               issued_d     = '0;
               abort_pend_d = 1'b0;
               state_d      = (transaction_count == CNT_ZERO) ? DONE : INIT;
            end
         end

         INIT: begin
            generator_initialize = 1'b1;
            abort_pend_d         = abort_eff;
            state_d              = abort_eff ? DONE : ISSUE;
         end

         ISSUE: begin
            request_valid = 1'b1;
            abort_pend_d  = abort_eff;
            if (request_ready) begin
               generator_enable = 1'b1;
               issued_d         = issued_q + CNT_ONE;
               if ((issued_d == count_lat_q) || abort_eff) begin
                  state_d = DONE;
               end else if (gap_lat_q == CNT_ZERO) begin
                  state_d = ISSUE;
               end else begin
                  gap_cnt_d = gap_lat_q;
                  state_d   = GAP;
               end
            end
         end

         GAP: begin
            abort_pend_d = abort_eff;
            if (abort_eff) begin
               state_d = DONE;
            end else if (gap_cnt_q == CNT_ONE) begin
               state_d = ISSUE;
            end else begin
               gap_cnt_d = gap_cnt_q - CNT_ONE;
            end
         end

         DONE: begin
            done         = 1'b1;
            abort_pend_d = 1'b0;
            state_d      = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Address is gated so the port reads zero whenever no request is offered.
   assign request_address = request_valid ? generator_address : '0;
   assign busy            = (state_q != IDLE);
   assign issued_count    = issued_q;

endmodule

// File: tb/tb_injection_sequencer.sv
// Directed bench for injection_sequencer with a behavioural address generator and
// a scoreboard of expected request addresses.

module tb_injection_sequencer;

   localparam int AW = 48;
   localparam int CW = 32;
   localparam logic [AW-1:0] POLY = 48'hB400_0000_0023;

   logic          clock = 1'b0;
   logic          resetn, start, abort, request_ready;
   logic [CW-1:0] transaction_count, gap_cycles;
   logic          generator_initialize, generator_enable, request_valid, busy, done;
   logic [AW-1:0] generator_address, request_address;
   logic [CW-1:0] issued_count;

   always #5 clock = ~clock;

   injection_sequencer #(.ADDRESS_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
      .clock                (clock),
      .resetn               (resetn),
      .start                (start),
      .abort                (abort),
      .transaction_count    (transaction_count),
      .gap_cycles           (gap_cycles),
      .generator_initialize (generator_initialize),
      .generator_enable     (generator_enable),
      .generator_address    (generator_address),
      .request_valid        (request_valid),
      .request_ready        (request_ready),
      .request_address      (request_address),
      .busy                 (busy),
      .done                 (done),
      .issued_count         (issued_count)
   );

   // behavioural address_generator: range or LFSR mode
   bit            gen_mode;
   logic [AW-1:0] gen_base, gen_inc, gen_q;

   function automatic logic [AW-1:0] gen_next(input logic [AW-1:0] a);
      if (gen_mode) return {a[AW-2:0], 1'b0} ^ (a[AW-1] ? POLY : '0);
      return a + gen_inc;
   endfunction

   always @(posedge clock or negedge resetn) begin
      if (!resetn)                   gen_q <= '0;
      else if (generator_initialize) gen_q <= gen_base;
      else if (generator_enable)     gen_q <= gen_next(gen_q);
   end
   assign generator_address = gen_q;

   int checks = 0;
   int errors = 0;
   logic [AW-1:0] exp_q[$];

   int cyc = 0, c0, hs_cnt, first_valid, done_cyc, valid_cycles, init_cnt, done_cnt, en_cnt;
   int last_hs, stall_req, stall_left, abort_req, abort_gap_k, exp_gap;
   bit exp_gap_chk, prev_stall, prev_valid, prev_hs, rdy_default, abort_manual;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      hs_cnt = 0; first_valid = -1; done_cyc = -1; valid_cycles = 0; init_cnt = 0;
      done_cnt = 0; en_cnt = 0; last_hs = 0; stall_req = -1; stall_left = 0;
      abort_req = -1; abort_gap_k = -1; exp_gap = 0; exp_gap_chk = 0;
      prev_stall = 0; prev_valid = 0; prev_hs = 0;
      exp_q.delete();
   endtask

   // Entered at posedge+1: drive ready/abort, sample at +2, then advance one clock.
   task automatic step();
      request_ready = rdy_default;
      abort         = abort_manual;
      if (request_valid && hs_cnt == stall_req && stall_left > 0) begin
         request_ready = 1'b0;
         stall_left--;
      end
      if (request_valid && hs_cnt == abort_req) abort = 1'b1;
      if (prev_hs && hs_cnt == abort_gap_k) abort = 1'b1;
      #1;
      cyc++;
      if (request_valid && first_valid < 0) first_valid = cyc;
      if (request_valid) valid_cycles++;
      if (generator_initialize) init_cnt++;
      if (generator_enable) en_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      chk("enable_eq_handshake", generator_enable, request_valid & request_ready);
      if (prev_stall) chk("valid_held", request_valid, 1'b1);
      if (request_valid && !request_ready && exp_q.size() > 0)
         chk("stall_addr", request_address, exp_q[0]);
      if (request_valid && !prev_valid && hs_cnt > 0 && exp_gap_chk)
         chk("gap_len", cyc - last_hs - 1, exp_gap);
      if (request_valid && request_ready) begin
         if (exp_q.size() == 0) chk("sb_extra_request", hs_cnt, -1);
         else chk("req_addr", request_address, exp_q.pop_front());
         hs_cnt++;
         last_hs = cyc;
      end
      prev_stall = request_valid & ~request_ready;
      prev_valid = request_valid;
      prev_hs    = request_valid & request_ready;
      @(posedge clock);
      #1;
   endtask

   task automatic do_start(input logic [CW-1:0] n, input logic [CW-1:0] g,
                           input int n_push, input bit with_abort);
      logic [AW-1:0] a;
      clear_stats();
      a = gen_base;
      for (int i = 0; i < n_push; i++) begin
         exp_q.push_back(a);
         a = gen_next(a);
      end
      transaction_count = n;
      gap_cycles        = g;
      start             = 1'b1;
      abort_manual      = with_abort;
      c0                = cyc + 1;
      step();
      start        = 1'b0;
      abort_manual = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && done_cyc < 0; i++) step();
      chk("done_seen", done_cyc >= 0, 1'b1);
   endtask

   task automatic finish_checks(input int exp_issued, input int exp_init);
      chk("issued_count", issued_count, exp_issued);
      chk("handshakes", hs_cnt, exp_issued);
      chk("enable_pulses", en_cnt, exp_issued);
      chk("init_pulses", init_cnt, exp_init);
      chk("done_pulses", done_cnt, 1);
      chk("sb_leftover", exp_q.size(), 0);
      step();
      chk("idle_after_done", {busy, done, request_valid}, 3'b000);
      chk("issued_holds", issued_count, exp_issued);
   endtask

   initial begin
      resetn = 1'b0; start = 1'b0; abort = 1'b0; request_ready = 1'b0;
      transaction_count = '0; gap_cycles = '0; abort_manual = 1'b0; rdy_default = 1'b1;
      gen_mode = 1'b0; gen_base = 48'h1000; gen_inc = 48'h40;
      clear_stats();
      #12;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_valid", request_valid, 1'b0);
      chk("rst_init", generator_initialize, 1'b0);
      chk("rst_enable", generator_enable, 1'b0);
      chk("rst_addr", request_address, 0);
      chk("rst_issued", issued_count, 0);
      @(negedge clock); resetn = 1'b1;
      @(posedge clock); #1;

      // range mode, count 4, back-to-back
      do_start(4, 0, 4, 1'b0);
      wait_done(20);
      chk("t1_first_valid", first_valid - c0, 2);
      chk("t1_done_cycle", done_cyc - c0, 6);
      chk("t1_valid_cycles", valid_cycles, 4);
      finish_checks(4, 1);

      // ready low for 3 cycles on the 2nd request
      do_start(4, 0, 4, 1'b0);
      stall_req = 1; stall_left = 3;
      wait_done(30);
      chk("t2_valid_cycles", valid_cycles, 7);
      chk("t2_done_cycle", done_cyc - c0, 9);
      finish_checks(4, 1);

      // count 3, gap 2; start and new config while busy must be ignored
      do_start(3, 2, 3, 1'b0);
      exp_gap = 2; exp_gap_chk = 1'b1;
      step(); step();
      start = 1'b1; transaction_count = 99; gap_cycles = 0;
      step();
      start = 1'b0;
      wait_done(30);
      chk("t3_done_cycle", done_cyc - c0, 9);
      finish_checks(3, 1);

      // count 0
      do_start(0, 0, 0, 1'b0);
      wait_done(5);
      chk("t4_done_cycle", done_cyc - c0, 1);
      chk("t4_valid_cycles", valid_cycles, 0);
      finish_checks(0, 0);

      // abort during stalled 3rd request
      do_start(10, 0, 3, 1'b0);
      stall_req = 2; stall_left = 3; abort_req = 2;
      wait_done(30);
      chk("t5_done_cycle", done_cyc - c0, 8);
      finish_checks(3, 1);

      // abort in GAP after the 2nd request
      do_start(5, 4, 2, 1'b0);
      abort_gap_k = 2;
      wait_done(40);
      chk("t6_done_after_abort", done_cyc - last_hs, 2);
      finish_checks(2, 1);

      // maximum count, abort on the 5th handshake cycle itself
      do_start('1, 0, 5, 1'b0);
      abort_req = 4;
      wait_done(30);
      chk("t7_done_cycle", done_cyc - c0, 7);
      finish_checks(5, 1);

      // reset in the middle of ISSUE, then a clean run
      rdy_default = 1'b0;
      do_start(4, 0, 4, 1'b0);
      for (int i = 0; i < 5 && !request_valid; i++) step();
      chk("t8_reached_issue", request_valid, 1'b1);
      resetn = 1'b0;
      #1;
      chk("t8_rst_valid", request_valid, 1'b0);
      chk("t8_rst_busy", busy, 1'b0);
      chk("t8_rst_done", done, 1'b0);
      chk("t8_rst_init_en", {generator_initialize, generator_enable}, 2'b00);
      chk("t8_rst_addr", request_address, 0);
      @(posedge clock); #1;
      resetn = 1'b1;
      rdy_default = 1'b1;
      do_start(2, 0, 2, 1'b0);
      wait_done(20);
      chk("t8_first_valid", first_valid - c0, 2);
      finish_checks(2, 1);

      // LFSR mode, 8 requests; start with simultaneous abort keeps start
      gen_mode = 1'b1; gen_base = 48'h0000_ACE1_1234;
      do_start(8, 0, 8, 1'b1);
      wait_done(30);
      chk("t9_done_cycle", done_cyc - c0, 10);
      finish_checks(8, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/injection_sequencer.md
Name: injection_sequencer

Overview:
Sequences one address_generator instance to issue a bounded burst of memory-injection requests.
- On start: pulses the generator's initialize, then emits transaction_count addresses on a valid/ready request port.
- Advances the generator exactly once per accepted request, with an optional programmable idle gap between requests.
- Sits between the configuration registers and the memory request port; reports busy, done and a running issued count.

Parameters:
ADDRESS_WIDTH, 48, width of generator_address and request_address.
COUNT_WIDTH, 32, width of transaction_count, issued_count and the gap counter.

Ports:
clock  in  1  system clock, rising edge.
resetn  in  1  asynchronous active-low reset.
start  in  1  single-cycle run request; honoured only in IDLE.
abort  in  1  single-cycle stop request; ignored in IDLE and DONE.
transaction_count  in  COUNT_WIDTH  number of requests to issue; latched on start.
gap_cycles  in  COUNT_WIDTH  idle cycles between consecutive requests; latched on start.
generator_initialize  out  1  drives address_generator.initialize.
generator_enable  out  1  drives address_generator.enable.
generator_address  in  ADDRESS_WIDTH  from address_generator.generated_address.
request_valid  out  1  request valid.
request_ready  in  1  downstream accept.
request_address  out  ADDRESS_WIDTH  request address; equals generator_address whenever request_valid is 1.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse at run end.
issued_count  out  COUNT_WIDTH  requests accepted in the current or last run.

Behaviour:
- Reset (asynchronous, resetn=0):
  - State goes to IDLE.
  - All outputs 0; issued_count=0; latched config and abort_pending cleared.
- States: IDLE, INIT, ISSUE, GAP, DONE.
- IDLE:
  - start=1 latches transaction_count and gap_cycles, clears issued_count and abort_pending.
  - If latched count=0, go to DONE; otherwise go to INIT.
  - abort in IDLE is ignored. start and abort in the same cycle: start accepted, abort dropped.
- INIT:
  - generator_initialize=1 for exactly one cycle, then go to ISSUE.
  - abort_pending set here: go to DONE instead, with 0 issued. The generator is still initialized.
- ISSUE:
  - request_valid=1 and request_address=generator_address.
  - Valid is held, with a stable address, until request_ready=1; it is never withdrawn before the handshake.
  - On the handshake cycle (valid & ready):
    - generator_enable=1 for that cycle only, so the next address is visible the following cycle.
    - issued_count increments.
    - If the new count equals the latched count, or abort_pending is set, go to DONE.
    - Else if gap_cycles=0, stay in ISSUE (back-to-back, valid stays high).
    - Else load the gap counter with gap_cycles and go to GAP.
- GAP:
  - request_valid=0; the counter decrements each cycle.
  - The cycle the counter reads 1, go to ISSUE. This gives exactly gap_cycles idle cycles.
  - abort_pending set: go to DONE next cycle.
- DONE:
  - done=1 for one cycle, then go to IDLE.
  - issued_count holds until the next start.
- abort handling:
  - abort in INIT/ISSUE/GAP sets abort_pending; it takes effect at the next legal exit point.
  - An outstanding request in ISSUE always completes; a request in flight is never dropped.
  - abort on the handshake cycle itself ends the run after that request.
- start while busy is ignored. Config input changes while busy have no effect.
- generator_enable is asserted only on handshake cycles and never in INIT, so no address is skipped or repeated.
- Latency with ready held 1: start at cycle 0, INIT at cycle 1, first request_valid at cycle 2.
- Width rules:
  - issued_count never exceeds the latched count; no wrap within a run.
  - transaction_count = 2^COUNT_WIDTH−1 must be supported.
  - All comparisons are unsigned.
- Reset asserted mid-run: immediate return to IDLE with all outputs 0. No done pulse.

Test Plan:
- Range mode, start=0x1000, increment=0x40, count=4, gap=0, ready=1:
  - Valid high cycles 2–5 with addresses 0x1000, 0x1040, 0x1080, 0x10C0.
  - done pulses at cycle 6; issued_count=4.
- Same config with ready low for 3 cycles on the 2nd request:
  - Valid and address 0x1040 held stable for those 3 cycles.
  - Exactly one enable pulse per handshake; total 4 requests.
- count=3, gap=2: two idle cycles between each handshake and the next valid; done after the 3rd accept.
- count=0: start, then DONE next cycle and done pulse. No initialize, no valid; issued_count=0.
- Abort tests:
  - count=10, abort during the 3rd request while ready=0: that request completes on ready, then done; issued_count=3.
  - Abort in GAP: done next cycle, no further valid.
- resetn low mid-ISSUE: outputs 0 immediately; a later start runs cleanly from INIT.
- LFSR mode: addresses match the generator's seed-then-step sequence for 8 requests.
